cbus_sram_responder: RTL

Memory-side responder for the cbus protocol: accepts one `cbus_req_t` transaction at a time from a cache or arbiter, and serves it from an internal 64-bit word array. Reads return beats on `cresp.data`, and writes commit `creq.data` under `creq.strobe`. The block sits behind the cbus arbiter in simulation and FPGA builds as the backing store for DCache/ICache line fills and write-backs. Latency to first beat and optional beat-level stalls are configurable so initiators can be exercised against realistic timing.

---
 rtl/cbus_sram_responder_if.sv | 25 ++
 rtl/cbus_sram_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cbus_sram_responder_if.sv
// cbus request/response bundle between an initiator (master) and the SRAM responder (slave).
// The request fields mirror cbus_req_t and the response fields mirror cbus_resp_t.
interface cbus_sram_responder_if;
  logic        req_valid;
  logic        req_is_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic [7:0]  req_len;
  logic [1:0]  req_burst;
  logic        resp_ready;
  logic        resp_last;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    input  resp_ready, resp_last, resp_data
  );

  modport slave (
    input  req_valid, req_is_write, req_size, req_addr, req_strobe, req_data, req_len, req_burst,
    output resp_ready, resp_last, resp_data
  );
endinterface

// File: rtl/cbus_sram_responder.sv
// cbus SRAM responder: single outstanding transaction served from a 64-bit word array.
// Optional feature macro: CBUS_RESP_BACKPRESSURE_EN (ready alternates 1,0 within a burst).
module cbus_sram_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input logic                  clk,
  input logic                  reset,
  cbus_sram_responder_if.slave cbus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [1:0] BURST_FIXED = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       beat_q, beat_d;
  logic [7:0]       len_q, len_d;
  logic             is_write_q, is_write_d;
  logic [2:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       burst_q, burst_d;
  logic             phase_q, phase_d;

  logic [63:0]      mem_q [MEM_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic             ready_s;
  logic             wr_en_s;
  logic             unused_s;

  function automatic logic [63:0] merge_lanes(input logic [63:0] old_w, input logic [63:0] new_w,
                                              input logic [7:0] strb);
    logic [63:0] res;
    res = old_w;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign idx_s    = addr_q[3 +: IDX_W];
  assign unused_s = ^{addr_q[31:IDX_W+3], addr_q[2:0]};
  assign ready_s  = (state_q == S_BURST) && phase_q;
  // A dropped valid mid-transaction aborts without writing or signalling last.
  assign wr_en_s  = ready_s && cbus.req_valid && is_write_q;

  assign cbus.resp_ready = ready_s;
  assign cbus.resp_last  = ready_s && cbus.req_valid && (beat_q == len_q);
  assign cbus.resp_data  = (ready_s && !is_write_q) ? mem_q[idx_s] : 64'd0;

  // Next-state and header/counter update logic.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    beat_d     = beat_q;
    len_d      = len_q;
    is_write_d = is_write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    phase_d    = phase_q;
    case (state_q)
      S_IDLE: begin
        if (cbus.req_valid) begin
          is_write_d = cbus.req_is_write;
          size_d     = cbus.req_size;
          addr_d     = cbus.req_addr;
          len_d      = cbus.req_len;
          burst_d    = cbus.req_burst;
          beat_d     = 8'd0;
          phase_d    = 1'b1;
          if (LATENCY == 0) begin
            state_d = S_BURST;
            lat_d   = '0;
          end else begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(LATENCY);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!cbus.req_valid) begin
          state_d = S_IDLE;
          lat_d   = '0;
        end else if (lat_q <= LAT_W'(1)) begin
          state_d = S_BURST;
          lat_d   = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_BURST: begin
        if (!cbus.req_valid) begin
          state_d = S_IDLE;
          beat_d  = 8'd0;
        end else if (ready_s) begin
          if (beat_q == len_q) begin
            state_d = S_IDLE;
            beat_d  = 8'd0;
          end else begin
            beat_d = beat_q + 8'd1;
            if (burst_q == BURST_FIXED) begin
              addr_d = addr_q;
            end else begin
              addr_d = addr_q + (32'd1 << size_q);
            end
          end
        end else begin
          state_d = S_BURST;
        end
`ifdef CBUS_RESP_BACKPRESSURE_EN
        phase_d = ~phase_q;
`else
        phase_d = 1'b1;
`endif
      end
      default: begin
        state_d = S_IDLE;
        lat_d   = '0;
        beat_d  = 8'd0;
      end
    endcase
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      beat_q     <= 8'd0;
      len_q      <= 8'd0;
      is_write_q <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 32'd0;
      burst_q    <= 2'd0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      phase_q    <= phase_d;
    end
  end

  // Storage array, deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_s] <= merge_lanes(mem_q[idx_s], cbus.req_data, cbus.req_strobe);
    end
  end
endmodule
